// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared state encoding, datapath op codes and round count for the AES decrypt control
package aes_ctrl_pkg;
  typedef enum logic [3:0] {IDLE, KEYGO, KEYWAIT, ARK0, ISR, ISB, ARK, IMC, MSGLD, DONE} state_e;
  localparam logic [1:0] OP_ARK = 2'd0;
  localparam logic [1:0] OP_ISR = 2'd1;
  localparam logic [1:0] OP_ISB = 2'd2;
  localparam logic [1:0] OP_IMC = 2'd3;
  localparam int AES128_ROUNDS = 10;
endpackage

// File: rtl/aes_dec_sequencer.sv
// aes_dec_sequencer: Moore control FSM stepping a single-state datapath through the AES inverse cipher
module aes_dec_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS    = AES128_ROUNDS,
  parameter bit MIXCOL_SERIAL = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       KEYEXP_GO,
  input  logic       KEYEXP_DONE,
  output logic       STATE_LD,
  output logic       STATE_WE,
  output logic [1:0] OP_SEL,
  output logic [3:0] ROUND_IDX,
  output logic [1:0] COL_SEL,
  output logic       MSG_LD,
  output logic       BUSY
);
  state_e     state, nxt;
  logic [3:0] rnd, rnd_n;
  logic [1:0] col, col_n;
  logic       start_q;
  // start_q resets high so a START level present at reset release is not taken as an edge
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state   <= IDLE;
      rnd     <= 4'd0;
      col     <= 2'd0;
      start_q <= 1'b1;
    end else begin
      state   <= nxt;
      rnd     <= rnd_n;
      col     <= col_n;
      start_q <= AES_START;
    end
  always_comb begin
    nxt   = state;
    rnd_n = rnd;
    col_n = col;
    case (state)
      IDLE:    nxt = (AES_START && !start_q) ? KEYGO : IDLE;
      KEYGO:   nxt = KEYWAIT;
      KEYWAIT: nxt = KEYEXP_DONE ? ARK0 : KEYWAIT;
      ARK0: begin
        nxt   = ISR;
        rnd_n = 4'(NUM_ROUNDS - 1);
      end
      ISR:     nxt = ISB;
      ISB:     nxt = ARK;
      ARK: begin
        nxt   = (rnd != 4'd0) ? IMC : MSGLD;
        col_n = 2'd0;
      end
      IMC:
        if (!MIXCOL_SERIAL || col == 2'd3) begin
          nxt   = ISR;
          rnd_n = (rnd != 4'd0) ? rnd - 4'd1 : rnd;
          col_n = 2'd0;
        end else col_n = col + 2'd1;
      MSGLD:   nxt = DONE;
      DONE:    nxt = AES_START ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign KEYEXP_GO = state == KEYGO;
  assign STATE_LD  = state == KEYGO;
  assign STATE_WE  = state inside {ARK0, ISR, ISB, ARK, IMC};
  assign OP_SEL    = state == ISR ? OP_ISR : state == ISB ? OP_ISB : state == IMC ? OP_IMC : OP_ARK;
  assign ROUND_IDX = state == ARK0 ? 4'(NUM_ROUNDS) : state == ARK ? rnd : 4'd0;
  assign COL_SEL   = (state == IMC && MIXCOL_SERIAL) ? col : 2'd0;
  assign MSG_LD    = state == MSGLD;
  assign AES_DONE  = state == DONE;
  assign BUSY      = !(state inside {IDLE, DONE});
endmodule
